// File: rtl/axi_ram_slave_if.sv
// rtl/axi_ram_slave_if.sv - Single-beat AXI ar/r/aw/w/b channel bundle between CPU master and RAM slave
interface axi_ram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - Single-beat AXI slave backed by a 32-bit word RAM
// Independent read and write FSMs; a same-edge write to the word being read is forwarded.
module axi_ram_slave #(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            resetn,
  axi_ram_slave_if.slave  bus
);
  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;

  logic [31:0] mem_q [DEPTH];

  r_state_e              r_state_q, r_state_d;
  logic [2:0]            r_cnt_q, r_cnt_d;
  logic [ADDR_WIDTH-1:0] r_idx_q, r_idx_d;
  logic [3:0]            rid_q, rid_d;
  logic [31:0]           rdata_q, rdata_d;

  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
  logic [3:0]            bid_q, bid_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [ADDR_WIDTH-1:0] ar_idx, aw_idx, rd_idx;
  logic [31:0]           rd_word;
  logic                  ar_hs, aw_hs, w_hs;
  logic                  unused_bits;

  assign ar_idx = bus.araddr[ADDR_WIDTH+1:2];
  assign aw_idx = bus.awaddr[ADDR_WIDTH+1:2];
  assign unused_bits = ^{bus.arlen, bus.arsize, bus.araddr, bus.awaddr};

  assign bus.arready = (r_state_q == R_IDLE);
  assign bus.rvalid  = (r_state_q == R_RESP);
  assign bus.rdata   = rdata_q;
  assign bus.rid     = rid_q;
  assign bus.rresp   = 2'b00;
  assign bus.rlast   = 1'b1;
  assign bus.awready = (w_state_q == W_IDLE) || (w_state_q == W_ADDR);
  assign bus.wready  = (w_state_q == W_IDLE) || (w_state_q == W_DATA);
  assign bus.bvalid  = (w_state_q == W_RESP);
  assign bus.bid     = bid_q;
  assign bus.bresp   = 2'b00;

  assign ar_hs = bus.arvalid && bus.arready;
  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    bid_d     = bid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wr_en     = 1'b0;
    wr_idx    = w_idx_q;
    wr_data   = wdata_q;
    wr_strb   = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_en     = 1'b1;
          wr_idx    = aw_idx;
          wr_data   = bus.wdata;
          wr_strb   = bus.wstrb;
          bid_d     = bus.awid;
          w_state_d = W_RESP;
        end else if (aw_hs) begin
          w_idx_d   = aw_idx;
          bid_d     = bus.awid;
          w_state_d = W_DATA;
        end else if (w_hs) begin
          wdata_d   = bus.wdata;
          wstrb_d   = bus.wstrb;
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: if (aw_hs) begin
        wr_en     = 1'b1;
        wr_idx    = aw_idx;
        bid_d     = bus.awid;
        w_state_d = W_RESP;
      end
      W_DATA: if (w_hs) begin
        wr_en     = 1'b1;
        wr_data   = bus.wdata;
        wr_strb   = bus.wstrb;
        w_state_d = W_RESP;
      end
      W_RESP: if (bus.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // The RAM array only updates at the edge, so a same-edge write is merged here to give write-first reads.
  assign rd_idx = (r_state_q == R_IDLE) ? ar_idx : r_idx_q;

  always_comb begin
    rd_word = mem_q[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_idx_d   = r_idx_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        rid_d   = bus.arid;
        r_idx_d = ar_idx;
        r_cnt_d = LAT_LOAD;
        if (READ_LATENCY == 1) begin
          rdata_d   = rd_word;
          r_state_d = R_RESP;
        end else begin
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        r_cnt_d = r_cnt_q - 3'd1;
        if (r_cnt_q == 3'd1) begin
          rdata_d   = rd_word;
          r_state_d = R_RESP;
        end
      end
      R_RESP: if (bus.rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_idx_q   <= '0;
      rid_q     <= '0;
      rdata_q   <= '0;
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      bid_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_idx_q   <= r_idx_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      bid_q     <= bid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end
endmodule
